// File: rtl/input_action_arbiter.sv
// Input action arbiter: synchronizes and debounces the left/right/fire buttons,
// turns each debounced press into one pending event, and hands events one at a
// time to the game FSM in round-robin order over a valid/ready handshake.
// Fire presses are dropped while the fire cooldown timer is running.
module input_action_arbiter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIRE_COOLDOWN   = 8
) (
  input  logic       clk_slow,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic       act_ready,
  output logic       act_valid,
  output logic [1:0] act_code,
  output logic       fire_ready
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int COOL_W = $clog2(FIRE_COOLDOWN + 1);

  typedef enum logic {
    IDLE,
    HOLD
  } arbState_e;

  logic [2:0]        syncChain_q [SYNC_STAGES];
  logic [2:0]        syncLevel;
  logic [2:0]        dbLevel_q, dbLevel_d;
  logic [CNT_W-1:0]  dbCnt_q [3];
  logic [CNT_W-1:0]  dbCnt_d [3];
  logic [2:0]        pressEvent;
  logic [2:0]        newPress;
  logic [2:0]        grantMask;
  logic [2:0]        pend_q, pend_d;
  logic [COOL_W-1:0] cooldown_q, cooldown_d;
  arbState_e         state_q;
  logic [1:0]        lastGrant_q;
  logic              actValid_q;
  logic [1:0]        actCode_q;
  logic [1:0]        cand0, cand1, cand2;
  logic              pickFound;
  logic [1:0]        pickIdx;
  logic              handshake;

  assign syncLevel  = syncChain_q[SYNC_STAGES-1];
  assign act_valid  = actValid_q;
  assign act_code   = actCode_q;
  assign fire_ready = (cooldown_q == '0);
  assign handshake  = (state_q == HOLD) && act_ready;

  // Shift each raw button through its synchronizer chain.
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) syncChain_q[s] <= '0;
    end else begin
      syncChain_q[0] <= btn;
      for (int s = 1; s < SYNC_STAGES; s++) syncChain_q[s] <= syncChain_q[s-1];
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles; flag 0->1 flips as presses.
  always_comb begin
    dbLevel_d  = dbLevel_q;
    pressEvent = '0;
    for (int i = 0; i < 3; i++) begin
      dbCnt_d[i] = dbCnt_q[i];
      if (syncLevel[i] == dbLevel_q[i]) begin
        dbCnt_d[i] = '0;
      end else if (dbCnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        dbLevel_d[i]  = syncLevel[i];
        dbCnt_d[i]    = '0;
        pressEvent[i] = syncLevel[i];
      end else begin
        dbCnt_d[i] = dbCnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Hold debounced levels and their counters.
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      dbLevel_q <= '0;
      for (int i = 0; i < 3; i++) dbCnt_q[i] <= '0;
    end else begin
      dbLevel_q <= dbLevel_d;
      for (int i = 0; i < 3; i++) dbCnt_q[i] <= dbCnt_d[i];
    end
  end

  // Round-robin pick starting just after the last granted button, plus pending and cooldown next state.
  always_comb begin
    cand0 = (lastGrant_q == 2'd2) ? 2'd0 : lastGrant_q + 2'd1;
    cand1 = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
    cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    pickFound = 1'b0;
    pickIdx   = 2'd0;
    if (pend_q[cand0]) begin
      pickFound = 1'b1;
      pickIdx   = cand0;
    end else if (pend_q[cand1]) begin
      pickFound = 1'b1;
      pickIdx   = cand1;
    end else if (pend_q[cand2]) begin
      pickFound = 1'b1;
      pickIdx   = cand2;
    end
    newPress  = pressEvent & {(cooldown_q == '0), 2'b11};
    grantMask = '0;
    if ((state_q == IDLE) && pickFound) grantMask[pickIdx] = 1'b1;
    pend_d = (pend_q & ~grantMask) | newPress;
    if (handshake && (actCode_q == 2'd2)) begin
      cooldown_d = COOL_W'(FIRE_COOLDOWN);
    end else if (cooldown_q != '0) begin
      cooldown_d = cooldown_q - COOL_W'(1);
    end else begin
      cooldown_d = cooldown_q;
    end
  end

  // Arbiter FSM with registered handshake outputs, pending events and fire cooldown.
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      state_q     <= IDLE;
      actValid_q  <= 1'b0;
      actCode_q   <= 2'd0;
      lastGrant_q <= 2'd2;
      pend_q      <= '0;
      cooldown_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      cooldown_q <= cooldown_d;
      case (state_q)
        IDLE: begin
          if (pickFound) begin
            actValid_q <= 1'b1;
            actCode_q  <= pickIdx;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (act_ready) begin
            actValid_q  <= 1'b0;
            lastGrant_q <= actCode_q;
            state_q     <= IDLE;
          end
        end
        default: begin
          actValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_action_arbiter.sv
// Testbench for input_action_arbiter: directed scenarios with a window-based
// behavioural model compared every cycle, plus literal spot checks.
module tb_input_action_arbiter;

  localparam int S = 2;
  localparam int D = 4;
  localparam int F = 8;

  logic       clk_slow = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn = 3'b000;
  logic       act_ready = 1'b0;
  logic       act_valid;
  logic [1:0] act_code;
  logic       fire_ready;

  int total = 0;
  int bad = 0;

  input_action_arbiter #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .FIRE_COOLDOWN(F)
  ) dut (
    .clk_slow(clk_slow),
    .reset(reset),
    .btn(btn),
    .act_ready(act_ready),
    .act_valid(act_valid),
    .act_code(act_code),
    .fire_ready(fire_ready)
  );

  // Free-running game clock.
  always #5 clk_slow = ~clk_slow;

  // Model state: raw button history, debounced levels, pending set, handshake, cooldown.
  logic [2:0] hist [0:255];
  int         edgeN = 0;
  bit         modelLive = 1'b0;
  logic       mValid;
  logic [1:0] mCode;
  int         mLast;
  logic [2:0] mPend;
  int         mCool;
  logic [2:0] mDb;

  function automatic logic [2:0] histAt(input int n);
    if (n < 0) return 3'b000;
    return hist[n % 256];
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a button's debounced level flips once the last D synchronized samples all differ from it.
  always @(posedge clk_slow) begin : model
    logic [2:0] rise;
    logic [2:0] tmp;
    bit         allDiff;
    bit         fireHs;
    int         pick;
    if (reset) begin
      for (int k = 0; k < 256; k++) hist[k] = 3'b000;
      mValid = 1'b0;
      mCode = 2'd0;
      mLast = 2;
      mPend = 3'b000;
      mCool = 0;
      mDb = 3'b000;
      modelLive = 1'b1;
    end else begin
      hist[edgeN % 256] = btn;
      rise = 3'b000;
      for (int i = 0; i < 3; i++) begin
        allDiff = 1'b1;
        for (int k = 0; k < D; k++) begin
          tmp = histAt(edgeN - S - k);
          if (tmp[i] == mDb[i]) allDiff = 1'b0;
        end
        if (allDiff) begin
          if (!mDb[i]) rise[i] = 1'b1;
          mDb[i] = ~mDb[i];
        end
      end
      if (mCool != 0) rise[2] = 1'b0;
      fireHs = mValid && act_ready && (mCode == 2'd2);
      if (mValid) begin
        if (act_ready) begin
          mValid = 1'b0;
          mLast = int'(mCode);
        end
      end else if (mPend != 3'b000) begin
        pick = 0;
        for (int k = 1; k <= 3; k++) begin
          pick = (mLast + k) % 3;
          if (mPend[pick]) break;
        end
        mValid = 1'b1;
        mCode = 2'(pick);
        mPend[pick] = 1'b0;
      end
      if (fireHs) mCool = F;
      else if (mCool > 0) mCool = mCool - 1;
      mPend = mPend | rise;
    end
    edgeN++;
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk_slow) begin
    if (modelLive) begin
      checkOutput("cyc_valid", {3'b0, act_valid}, {3'b0, mValid});
      checkOutput("cyc_fire_ready", {3'b0, fire_ready}, {3'b0, (mCool == 0)});
      if (mValid) checkOutput("cyc_code", {2'b0, act_code}, {2'b0, mCode});
    end
  end

  task automatic applyStimulus(input logic [2:0] b, input logic r, input logic rst, input int n);
    btn = b;
    act_ready = r;
    reset = rst;
    repeat (n) @(posedge clk_slow);
    @(negedge clk_slow);
  endtask

  task automatic doReset();
    applyStimulus(3'b000, 1'b0, 1'b1, 2);
  endtask

  // Runs n edges with fixed inputs, recording valid rises (edge index and codes) and fire_ready low cycles.
  task automatic watchRun(input logic [2:0] b, input logic r, input int n,
                          output int nRise, output int firstEdge,
                          output logic [1:0] code0, output logic [1:0] code1, output int fireLow);
    logic prev;
    prev = act_valid;
    nRise = 0;
    firstEdge = -1;
    code0 = 2'd0;
    code1 = 2'd0;
    fireLow = 0;
    btn = b;
    act_ready = r;
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk_slow);
      @(negedge clk_slow);
      if (!fire_ready) fireLow++;
      if (act_valid && !prev) begin
        if (nRise == 0) begin
          firstEdge = k;
          code0 = act_code;
        end else if (nRise == 1) begin
          code1 = act_code;
        end
        nRise++;
      end
      prev = act_valid;
    end
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int nRise, firstEdge, fireLow;
    logic [1:0] c0, c1;

    // Reset held with all buttons down-pressed.
    btn = 3'b111;
    act_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk_slow);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_slow);
      @(negedge clk_slow);
      checkOutput("rst_valid", {3'b0, act_valid}, 4'd0);
      checkOutput("rst_fire_ready", {3'b0, fire_ready}, 4'd1);
      checkOutput("rst_code", {2'b0, act_code}, 4'd0);
    end
    watchRun(3'b111, 1'b1, 30, nRise, firstEdge, c0, c1, fireLow);
    checkOutput("rst_release_first_edge", 4'(firstEdge), 4'd6);
    checkOutput("rst_release_code0", {2'b0, c0}, 4'd0);
    checkOutput("rst_release_code1", {2'b0, c1}, 4'd1);
    checkOutput("rst_release_actions", 4'(nRise), 4'd3);
    applyStimulus(3'b000, 1'b1, 1'b0, 10);

    // Bounce on left, then a steady press.
    applyStimulus(3'b001, 1'b1, 1'b0, 1);
    applyStimulus(3'b000, 1'b1, 1'b0, 1);
    applyStimulus(3'b001, 1'b1, 1'b0, 1);
    applyStimulus(3'b000, 1'b1, 1'b0, 1);
    watchRun(3'b001, 1'b1, 20, nRise, firstEdge, c0, c1, fireLow);
    checkOutput("bounce_actions", 4'(nRise), 4'd1);
    checkOutput("bounce_first_edge", 4'(firstEdge), 4'd6);
    checkOutput("bounce_code", {2'b0, c0}, 4'd0);
    applyStimulus(3'b000, 1'b1, 1'b0, 10);

    // Simultaneous left and right.
    doReset();
    watchRun(3'b011, 1'b1, 20, nRise, firstEdge, c0, c1, fireLow);
    checkOutput("rr_actions", 4'(nRise), 4'd2);
    checkOutput("rr_code0", {2'b0, c0}, 4'd0);
    checkOutput("rr_code1", {2'b0, c1}, 4'd1);
    applyStimulus(3'b000, 1'b1, 1'b0, 10);

    // Backpressure with right pressed while left is held.
    doReset();
    applyStimulus(3'b001, 1'b0, 1'b0, 7);
    checkOutput("bp_valid_up", {3'b0, act_valid}, 4'd1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(3'b011, 1'b0, 1'b0, 1);
      checkOutput("bp_hold_valid", {3'b0, act_valid}, 4'd1);
      checkOutput("bp_hold_code", {2'b0, act_code}, 4'd0);
    end
    applyStimulus(3'b011, 1'b0, 1'b0, 3);
    watchRun(3'b011, 1'b1, 10, nRise, firstEdge, c0, c1, fireLow);
    checkOutput("bp_next_actions", 4'(nRise), 4'd1);
    checkOutput("bp_next_code", {2'b0, c0}, 4'd1);
    applyStimulus(3'b000, 1'b1, 1'b0, 10);

    // Fire cooldown drops an early re-press.
    doReset();
    applyStimulus(3'b100, 1'b0, 1'b0, 7);
    checkOutput("fire_valid_up", {3'b0, act_valid}, 4'd1);
    checkOutput("fire_code", {2'b0, act_code}, 4'd2);
    applyStimulus(3'b000, 1'b0, 1'b0, 4);
    applyStimulus(3'b100, 1'b0, 1'b0, 2);
    applyStimulus(3'b100, 1'b1, 1'b0, 1);
    checkOutput("fire_hs_valid", {3'b0, act_valid}, 4'd0);
    checkOutput("fire_hs_ready", {3'b0, fire_ready}, 4'd0);
    watchRun(3'b100, 1'b1, 12, nRise, firstEdge, c0, c1, fireLow);
    checkOutput("fire_cool_low_cycles", 4'(fireLow), 4'd7);
    checkOutput("fire_dropped_actions", 4'(nRise), 4'd0);
    applyStimulus(3'b000, 1'b1, 1'b0, 6);
    watchRun(3'b100, 1'b1, 10, nRise, firstEdge, c0, c1, fireLow);
    checkOutput("fire_again_actions", 4'(nRise), 4'd1);
    checkOutput("fire_again_edge", 4'(firstEdge), 4'd6);
    checkOutput("fire_again_code", {2'b0, c0}, 4'd2);
    applyStimulus(3'b000, 1'b1, 1'b0, 10);

    // Reset while an action is held and right is pending.
    doReset();
    applyStimulus(3'b011, 1'b0, 1'b0, 10);
    checkOutput("midrst_held", {3'b0, act_valid}, 4'd1);
    applyStimulus(3'b000, 1'b0, 1'b1, 1);
    checkOutput("midrst_dropped", {3'b0, act_valid}, 4'd0);
    watchRun(3'b000, 1'b1, 15, nRise, firstEdge, c0, c1, fireLow);
    checkOutput("midrst_no_action", 4'(nRise), 4'd0);
    checkOutput("midrst_fire_ready", {3'b0, fire_ready}, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_action_arbiter.md
Name: input_action_arbiter

Overview:
- Turns the raw player buttons (left, right, fire) into clean, one-shot game actions.
- Each button goes through a DFF synchronizer chain and a per-button debounce counter; a rising debounced level then becomes one pending event.
- A round-robin arbiter hands one action at a time to the game-state FSM over a valid/ready handshake.
- A cooldown timer rate-limits fire actions. Sits between the board buttons and the player/projectile logic, on the slow game clock.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each button synchronizer chain (≥2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized level must differ from the debounced level before it is accepted (≥2).
- FIRE_COOLDOWN, 8, cycles after a fire handshake during which new fire presses are dropped (≥1).

Ports:
- clk_slow  input  1  game clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn  input  3  raw buttons; bit0 = left, bit1 = right, bit2 = fire; asynchronous, bouncy.
- act_ready  input  1  game FSM can accept an action this cycle.
- act_valid  output  1  action presented.
- act_code  output  2  0 = left, 1 = right, 2 = fire; 3 never driven.
- fire_ready  output  1  high when the fire cooldown counter is 0.

Behaviour:

Reset (synchronous, reset=1 at a clk_slow edge):
- Cleared: sync flops, debounced levels, debounce counters, pending bits, cooldown.
- act_valid = 0, act_code = 0, fire_ready = 1, arbiter in IDLE, last_grant = 2 (left has first priority).
- Reset asserted mid-operation behaves identically: a held act_valid drops at that edge and pending events are discarded.
- Buttons still held at reset release produce a fresh press, because the sync flops restart from 0.

Synchronizer:
- Per-bit shift through SYNC_STAGES flops.
- sync[i] is the last stage.

Debounce (per button i; counter width $clog2(DEBOUNCE_CYCLES+1)):
- If sync[i] == db[i]: cnt[i] <= 0.
- Else if cnt[i] == DEBOUNCE_CYCLES-1: db[i] <= sync[i], cnt[i] <= 0.
- Else: cnt[i] <= cnt[i] + 1.
- Glitches shorter than DEBOUNCE_CYCLES cycles never change db.

Press event:
- An edge where db[i] goes 0→1 sets pend[i] at that same edge.
- Releases (1→0) generate nothing.
- pend holds at most one event per button; a second press while pending merges into it.
- Fire exception: a fire press while cooldown ≠ 0 is dropped (pend[2] is not set).

Arbiter FSM:
- IDLE:
  - If any pend bit is set, pick the first set bit searching from (last_grant+1) mod 3 upward with wrap.
  - At that edge: act_code <= pick, act_valid <= 1, pend[pick] <= 0, go to HOLD.
  - If a new press of the same button lands on that same edge, the set wins and pend stays 1.
- HOLD:
  - act_valid and act_code stay stable until act_ready is high.
  - On act_valid & act_ready at an edge: act_valid <= 0, last_grant <= act_code; if act_code == 2, cooldown <= FIRE_COOLDOWN; go to IDLE.
  - Consequence: successive actions are separated by at least one cycle with act_valid low.
- act_ready while act_valid is low is ignored.

Cooldown:
- Decrements by 1 each cycle while nonzero.
- Width $clog2(FIRE_COOLDOWN+1).
- fire_ready = (cooldown == 0), registered-state based, no combinational path from inputs.

Latency:
- Measured from the first clk_slow edge that samples a clean high on btn[i], with the arbiter IDLE and nothing else pending.
- db rises at edge index SYNC_STAGES+DEBOUNCE_CYCLES-1.
- act_valid is high after edge index SYNC_STAGES+DEBOUNCE_CYCLES.
- Defaults: db rises at edge 5, act_valid high after edge 6.

Simultaneous presses:
- All pend bits are set; they are served one per handshake in round-robin order.

Test Plan:
- Reset: reset=1 for 3 edges with btn=3'b111 → act_valid=0, fire_ready=1 throughout; after release, the first act_valid has act_code=0 at edge index 6 after release.
- Bounce: btn[0] pattern 1,0,1,0 on successive edges, then steady 1 for 20 edges, act_ready=1 → exactly one action, code 0, act_valid high after edge 6 of the steady run, and no second action.
- Round robin: btn[0] and btn[1] rise on the same edge, act_ready=1 → code 0 then code 1, with act_valid low for ≥1 cycle between them.
- Backpressure: act_ready=0 for 5 edges with a left action pending, right pressed meanwhile → act_valid/act_code=0 held stable for 5 edges; after act_ready=1, code 1 is delivered next.
- Fire cooldown: fire handshake, then a fire press debounced 3 cycles later → no event, fire_ready=0 for 8 cycles then 1; a fire press debounced afterwards → action code 2.
- Reset mid-HOLD: reset=1 while act_valid=1 and act_ready=0, with btn[1] pending → act_valid=0 after that edge and no action is issued after release unless a new press occurs.
